// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared AES definitions for the sequential InvMixColumns block: byte/state
// types, the controller state encoding and the GF(2^8) xtime helper.
package inv_mix_columns_seq_pkg;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [31:0]  aes_col_t;
    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } imc_state_e;

    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
    localparam aes_byte_t AES_REDUCE = 8'h1b;

    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_REDUCE : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns of one 32-bit column (row 0 in bits 31:24),
// each constant multiply built from an xtime chain plus XOR.
module inv_mix_column
    import inv_mix_columns_seq_pkg::*;
(
    input  aes_col_t col,
    output aes_col_t mixed
);

    aes_byte_t s   [4];
    aes_byte_t x2  [4];
    aes_byte_t x4  [4];
    aes_byte_t x8  [4];
    aes_byte_t m09 [4];
    aes_byte_t m0b [4];
    aes_byte_t m0d [4];
    aes_byte_t m0e [4];

    for (genvar r = 0; r < 4; r++) begin : g_row
        assign s[r]   = col[31-8*r -: 8];
        assign x2[r]  = xtime(s[r]);
        assign x4[r]  = xtime(x2[r]);
        assign x8[r]  = xtime(x4[r]);
        // 9 = 8+1, b = 8+2+1, d = 8+4+1, e = 8+4+2
        assign m09[r] = x8[r] ^ s[r];
        assign m0b[r] = x8[r] ^ x2[r] ^ s[r];
        assign m0d[r] = x8[r] ^ x4[r] ^ s[r];
        assign m0e[r] = x8[r] ^ x4[r] ^ x2[r];
    end

    for (genvar r = 0; r < 4; r++) begin : g_out
        assign mixed[31-8*r -: 8] = m0e[r] ^ m0b[(r+1)%4] ^ m0d[(r+2)%4] ^ m09[(r+3)%4];
    end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: COLS_PER_CYCLE (1, 2 or 4) columns per BUSY cycle.
// Defining INV_MIX_COLUMNS_BYPASS_EN adds a bypass input that passes a state through untouched.
module inv_mix_columns_seq
    import inv_mix_columns_seq_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t in_data,
`ifdef INV_MIX_COLUMNS_BYPASS_EN
    input  logic       bypass,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t out_data,
    output imc_state_e fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready may depend on out_ready so DONE can hand over with no bubble.

    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    imc_state_e fsm;
    logic [1:0] col_cnt;
    aes_state_t work;
    aes_state_t work_next;
    logic       accept;
    logic       skip;

    logic [1:0] col_idx [COLS_PER_CYCLE];
    aes_col_t   col_in  [COLS_PER_CYCLE];
    aes_col_t   col_out [COLS_PER_CYCLE];

    assign in_ready  = (fsm == IDLE) || (fsm == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign fsm_state = fsm;

`ifdef INV_MIX_COLUMNS_BYPASS_EN
    assign skip = bypass;
`else
    assign skip = 1'b0;
`endif

    // Column c occupies bits {~c, 5'h1f} down to 32 bits below.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx[g] = col_cnt + 2'(g);
        assign col_in[g]  = work[{~col_idx[g], 5'h1f} -: 32];

        inv_mix_column u_col (
            .col   (col_in[g]),
            .mixed (col_out[g])
        );
    end

    always_comb begin
        work_next = work;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            work_next[{~col_idx[i], 5'h1f} -: 32] = col_out[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= IDLE;
            col_cnt   <= '0;
            work      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    if (accept) begin
                        work    <= in_data;
                        col_cnt <= '0;
                        if (skip) begin
                            fsm       <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                        end else begin
                            fsm       <= BUSY;
                            out_valid <= 1'b0;
                        end
                    end else if (fsm == DONE && out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    work    <= work_next;
                    col_cnt <= col_cnt + STEP;
                    if (col_cnt == LAST) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= work_next;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: three instances (1, 2 and 4 columns per cycle)
// checked against a GF(2^8) long-multiplication reference model.
module tb_inv_mix_columns_seq;
    import inv_mix_columns_seq_pkg::*;

    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         bypass    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    imc_state_e   fsm_state [3];

    int n_cmp  = 0;
    int n_fail = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << k)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .in_data   (in_data[k]),
`ifdef INV_MIX_COLUMNS_BYPASS_EN
            .bypass    (bypass[k]),
`endif
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k]),
            .fsm_state (fsm_state[k])
        );
    end

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // reference model: polynomial product then reduction by long division
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (y[i]) p ^= 15'(x) << i;
        for (int j = 14; j >= 8; j--)
            if (p[j]) p ^= 15'h11b << (j - 8);
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_imc(input logic [127:0] s);
        logic [7:0]   b [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(4*c+w) -: 8] = gmul(8'h0e, b[4*c+w])       ^ gmul(8'h0b, b[4*c+(w+1)%4]) ^
                                        gmul(8'h0d, b[4*c+(w+2)%4]) ^ gmul(8'h09, b[4*c+(w+3)%4]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic send(input int k, input logic [127:0] d);
        int tries;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        tries = 0;
        while (!in_ready[k] && tries < 20) begin
            @(posedge clk); #1;
            tries++;
        end
        check("accept_ready", 128'(in_ready[k]), 128'(1));
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
    endtask

    // lat = rising edges from the accept edge until out_valid is seen
    task automatic wait_out(input int k, input logic [127:0] exp, input int lat);
        int cnt;
        cnt = 0;
        while (!out_valid[k] && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("latency",   128'(cnt),          128'(lat));
        check("out_valid", 128'(out_valid[k]), 128'(1));
        check("out_data",  out_data[k],        exp);
    endtask

    task automatic consume(input int k);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        check("drain_valid", 128'(out_valid[k]), 128'(0));
        check("drain_state", 128'(fsm_state[k]), 128'(IDLE));
    endtask

    // stimulus
    initial begin
        logic [127:0] d;
        logic [127:0] d2;
        logic         byp;

        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; in_data[k] = '0; bypass[k] = 1'b0; out_ready[k] = 1'b0;
        end
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            check("rst_out_valid", 128'(out_valid[k]), 128'(0));
            check("rst_out_data",  out_data[k],        128'(0));
            check("rst_in_ready",  128'(in_ready[k]),  128'(1));
            check("rst_state",     128'(fsm_state[k]), 128'(IDLE));
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // known single-column and four-column vectors
        for (int k = 0; k < 3; k++) begin
            send(k, {32'h8e4da1bc, 96'h0});
            wait_out(k, {32'hdb135345, 96'h0}, 4 >> k);
            consume(k);
            send(k, 128'h9fdc589d_01010101_c6c6c6c6_4d7ebdf8);
            wait_out(k, 128'hf20a225c_01010101_c6c6c6c6_2d26314c, 4 >> k);
            consume(k);
        end

        // random states against the model
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 6; n++) begin
                d   = {$urandom(), $urandom(), $urandom(), $urandom()};
                byp = 1'b0;
`ifdef INV_MIX_COLUMNS_BYPASS_EN
                byp = 1'($urandom_range(0, 1));
                bypass[k] = byp;
`endif
                send(k, d);
                bypass[k] = 1'b0;
                wait_out(k, byp ? d : ref_imc(d), byp ? 0 : 4 >> k);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                consume(k);
            end
        end

        // output stalled in DONE, then back-to-back handover
        for (int k = 0; k < 3; k++) begin
            d  = {$urandom(), $urandom(), $urandom(), $urandom()};
            d2 = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(k, d);
            wait_out(k, ref_imc(d), 4 >> k);
            in_valid[k] = 1'b1;
            in_data[k]  = d2;
            for (int c = 0; c < 10; c++) begin
                check("stall_valid",    128'(out_valid[k]), 128'(1));
                check("stall_data",     out_data[k],        ref_imc(d));
                check("stall_in_ready", 128'(in_ready[k]),  128'(0));
                @(posedge clk); #1;
            end
            out_ready[k] = 1'b1;
            #1;
            check("b2b_in_ready", 128'(in_ready[k]), 128'(1));
            @(posedge clk); #1;
            out_ready[k] = 1'b0;
            in_valid[k]  = 1'b0;
            check("b2b_state", 128'(fsm_state[k]), 128'(BUSY));
            wait_out(k, ref_imc(d2), 4 >> k);
            consume(k);
        end

`ifdef INV_MIX_COLUMNS_BYPASS_EN
        for (int k = 0; k < 3; k++) begin
            bypass[k] = 1'b1;
            send(k, 128'h00112233445566778899aabbccddeeff);
            bypass[k] = 1'b0;
            wait_out(k, 128'h00112233445566778899aabbccddeeff, 0);
            consume(k);
            send(k, 128'h00112233445566778899aabbccddeeff);
            wait_out(k, ref_imc(128'h00112233445566778899aabbccddeeff), 4 >> k);
            consume(k);
        end
`endif

        // asynchronous reset in the middle of BUSY
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(0, d);
        @(posedge clk); #1;
        check("pre_rst_state", 128'(fsm_state[0]), 128'(BUSY));
        #2 rst = 1'b0;
        #1;
        check("arst_out_valid", 128'(out_valid[0]), 128'(0));
        check("arst_out_data",  out_data[0],        128'(0));
        check("arst_state",     128'(fsm_state[0]), 128'(IDLE));
        check("arst_in_ready",  128'(in_ready[0]),  128'(1));
        @(negedge clk) rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("post_rst_valid", 128'(out_valid[0]), 128'(0));
        end
        send(0, d);
        wait_out(0, ref_imc(d), 4);
        consume(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
